// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
//   Shared definitions for the 16-bit instruction-fetch bus.
//   - SIZE_* : transfer size encodings carried on size_i
//   - RESET_VECTOR : byte address the fetch unit starts from after reset
//   - resp_state_e : responder FSM state encoding (2-bit)
// ---------------------------------------------------------------------------
package bus_pkg;

  localparam logic [1:0] SIZE_IDLE = 2'b00;
  localparam logic [1:0] SIZE_BYTE = 2'b01;
  localparam logic [1:0] SIZE_HALF = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  localparam logic [63:0] RESET_VECTOR = 64'hFFFF_FFFF_FFFF_FF00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ACK  = 2'b10
  } resp_state_e;

endpackage

// File: rtl/fetch_responder_if.sv
// ---------------------------------------------------------------------------
// fetch_responder_if
//   Fetch-bus signal bundle between the fetch unit (master) and the
//   responder (slave).
//   adr_i  [63:0] byte address of the transfer            (master -> slave)
//   size_i [1:0]  00 idle, 01 byte, 10 halfword, 11 illegal (master -> slave)
//   ack_o         transfer complete this cycle             (slave -> master)
//   dat_o  [15:0] read data, valid while ack_o=1           (slave -> master)
//   err_o         acked transfer faulted                   (slave -> master)
//
// Handshake: size_i != 00 acts as the request valid. The master holds adr_i
// and size_i stable until the cycle in which ack_o=1 and samples dat_o/err_o
// at the end of that cycle. ack_o is a single-cycle completion pulse and is
// never asserted in two consecutive cycles. Dropping size_i to 00 before the
// ack abandons the transfer and no ack follows.
// ---------------------------------------------------------------------------
interface fetch_responder_if;

  logic [63:0] adr_i;
  logic [1:0]  size_i;
  logic        ack_o;
  logic [15:0] dat_o;
  logic        err_o;

  modport master (
    output adr_i,
    output size_i,
    input  ack_o,
    input  dat_o,
    input  err_o
  );

  modport slave (
    input  adr_i,
    input  size_i,
    output ack_o,
    output dat_o,
    output err_o
  );

endinterface

// File: rtl/hw_ram.sv
// ---------------------------------------------------------------------------
// hw_ram
//   2^DEPTH_LOG2 x 16 synchronous RAM, one write port and one registered
//   read port. A write and a read of the same word in the same cycle return
//   the old contents. Contents are not reset.
//   clk_i            clock
//   we_i             write strobe
//   waddr_i, wdata_i write halfword index / data
//   re_i             read enable; rdata_o updates on the next rising edge
//   raddr_i          read halfword index
//   rdata_o          registered read data
// ---------------------------------------------------------------------------
module hw_ram #(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [15:0]           wdata_i,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [15:0]           rdata_o
);

  logic [15:0] mem_q [2**DEPTH_LOG2];
  logic [15:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fetch_responder.sv
// ---------------------------------------------------------------------------
// fetch_responder
//   Answers fetch-bus read cycles from a local halfword memory after
//   WAIT_STATES extra cycles. Requests are accepted in IDLE, optionally
//   counted down in WAIT, and completed by a one-cycle ACK.
//   clk_i        clock
//   reset_ni     asynchronous active-low reset
//   bus          fetch bus, slave side (adr_i, size_i, ack_o, dat_o, err_o)
//   load_we_i    preload write strobe
//   load_adr_i   preload halfword index
//   load_dat_i   preload data
//   state_o      current FSM state (debug)
//   wcnt_o       current wait-state counter (debug)
// ---------------------------------------------------------------------------
module fetch_responder
  import bus_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter logic [63:0] BASE        = 64'hFFFF_FFFF_FFFF_F800,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  fetch_responder_if.slave      bus,
  input  logic                  load_we_i,
  input  logic [DEPTH_LOG2-1:0] load_adr_i,
  input  logic [15:0]           load_dat_i,
  output resp_state_e           state_o,
  output logic [3:0]            wcnt_o
);

  localparam logic [3:0] WCNT_INIT =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  resp_state_e state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [63:0] adr_q, adr_d;
  logic [1:0]  size_q, size_d;
  logic        err_q, err_d;
  logic        is_byte_q, is_byte_d;
  logic        hi_q, hi_d;

  logic        enter_ack;
  logic [63:0] req_adr;
  logic [1:0]  req_size;
  logic [63:0] offset;
  logic        in_range;
  logic        fault;
  logic [15:0] ram_rdata;
  logic        ack;
  logic [15:0] dat_out;

  // In IDLE the request has not been captured yet, so decode straight from
  // the bus; that lets WAIT_STATES=0 reach ACK in the next cycle.
  assign req_adr  = (state_q == ST_IDLE) ? bus.adr_i  : adr_q;
  assign req_size = (state_q == ST_IDLE) ? bus.size_i : size_q;

  // Subtraction wraps for addresses below BASE, so a single unsigned
  // compare covers both sides of the window.
  assign offset   = req_adr - BASE;
  assign in_range = (offset >> (DEPTH_LOG2 + 1)) == 64'd0;
  assign fault    = !in_range
                  || (req_size == SIZE_ILL)
                  || ((req_size == SIZE_HALF) && req_adr[0]);

  // Next-state and decode capture
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    adr_d     = adr_q;
    size_d    = size_q;
    err_d     = err_q;
    is_byte_d = is_byte_q;
    hi_d      = hi_q;
    enter_ack = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.size_i != SIZE_IDLE) begin
          adr_d  = bus.adr_i;
          size_d = bus.size_i;
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            wcnt_d  = WCNT_INIT;
          end else begin
            state_d   = ST_ACK;
            enter_ack = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (bus.size_i == SIZE_IDLE) begin
          state_d = ST_IDLE;
        end else if (wcnt_q == 4'd0) begin
          state_d   = ST_ACK;
          enter_ack = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        // Unconditional: a request still held here is the one just acked.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (enter_ack) begin
      err_d     = fault;
      is_byte_d = (req_size == SIZE_BYTE);
      hi_d      = req_adr[0];
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= ST_IDLE;
      wcnt_q    <= 4'd0;
      adr_q     <= 64'd0;
      size_q    <= SIZE_IDLE;
      err_q     <= 1'b0;
      is_byte_q <= 1'b0;
      hi_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      adr_q     <= adr_d;
      size_q    <= size_d;
      err_q     <= err_d;
      is_byte_q <= is_byte_d;
      hi_q      <= hi_d;
    end
  end

  // The read is launched on the edge that enters ACK, so the registered
  // RAM output lines up with the ACK cycle.
  hw_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (load_we_i),
    .waddr_i (load_adr_i),
    .wdata_i (load_dat_i),
    .re_i    (enter_ack),
    .raddr_i (offset[DEPTH_LOG2:1]),
    .rdata_o (ram_rdata)
  );

  assign ack = (state_q == ST_ACK);

  // Data and error are forced to zero outside ACK and on faults; both
  // drop immediately with an asynchronous reset because ack follows state.
  always_comb begin
    dat_out = 16'h0000;
    if (ack && !err_q) begin
      if (is_byte_q) begin
        dat_out = {8'h00, hi_q ? ram_rdata[15:8] : ram_rdata[7:0]};
      end else begin
        dat_out = ram_rdata;
      end
    end
  end

  assign bus.ack_o = ack;
  assign bus.dat_o = dat_out;
  assign bus.err_o = ack && err_q;

  assign state_o = state_q;
  assign wcnt_o  = wcnt_q;

endmodule

// File: doc/fetch_responder.md
# fetch_responder

Bus responder for the 16-bit instruction-fetch bus. It answers read cycles issued by the fetch unit (address, size, ack, data) from a local halfword memory, with a configurable number of wait states. It sits between the fetch unit and the boot/instruction store, and the bench uses it as the memory model. A side-band load port preloads memory contents.

## Interface
- `DEPTH_LOG2`, default 10: memory holds 2^DEPTH_LOG2 halfwords.
- `BASE`, default 64'hFFFF_FFFF_FFFF_F800: byte address of halfword 0. Must be aligned to 2^(DEPTH_LOG2+1) bytes.
- `WAIT_STATES`, default 0, range 0..15: extra cycles inserted before `ack_o`.
- `clk_i` in 1: clock; all state changes on the rising edge.
- `reset_ni` in 1: active-low reset, asynchronous assert; deassertion is synchronised externally.
- `adr_i` in 64: byte address of the transfer.
- `size_i` in 2: 00 idle, 01 byte, 10 halfword, 11 illegal.
- `ack_o` out 1: transfer complete; `dat_o` and `err_o` are valid in this cycle.
- `dat_o` out 16: read data.
- `err_o` out 1: the acked transfer faulted.
- `load_we_i` in 1: preload write strobe.
- `load_adr_i` in DEPTH_LOG2: preload halfword index.
- `load_dat_i` in 16: preload data.

## Operation
- States: IDLE, WAIT, ACK (2-bit encoding); `wcnt` is a 4-bit down-counter.
- IDLE:
  - If `size_i` != 00, capture `adr_i` and `size_i`.
  - Go to WAIT with `wcnt` = WAIT_STATES-1 if WAIT_STATES > 0; otherwise go straight to ACK.
- WAIT:
  - If `size_i` = 00, abort to IDLE; no ack is issued.
  - Else if `wcnt` = 0, go to ACK.
  - Else decrement `wcnt`.
- ACK:
  - `ack_o` = 1 for exactly one cycle, then return to IDLE unconditionally.
  - A request still present during the ACK cycle is treated as the completed one and is not restarted.
  - The next request is sampled in IDLE.
- Decode (registered on entry to ACK):
  - offset = captured adr − BASE; in range if offset < 2^(DEPTH_LOG2+1).
  - Halfword, adr[0]=0, in range: `dat_o` = mem[offset[DEPTH_LOG2:1]], `err_o` = 0.
  - Byte, in range: `dat_o` = {8'h00, selected byte}. adr[0]=0 selects the low byte [7:0]; adr[0]=1 selects the high byte [15:8].
  - Fault: halfword with adr[0]=1, size 11, or out of range. `dat_o` = 16'h0000, `err_o` = 1, and the ack is still issued.
- Outside ACK: `dat_o` = 0 and `err_o` = 0.
- Load port:
  - `load_we_i` writes mem[`load_adr_i`] ← `load_dat_i` on the clock edge.
  - A load in the same cycle as a memory read returns the old data; write-first is not required.
- Memory contents are not affected by reset.

## Timing
- Reset values: state IDLE, `ack_o` 0, `dat_o` 16'h0000, `err_o` 0, `wcnt` 0.
- Reset asserted mid-transfer abandons the transfer immediately; no ack follows reset release.
- Latency: a request first seen in IDLE in cycle N is acked in cycle N+1+WAIT_STATES.
- Initiator rule: hold `adr_i` and `size_i` stable until the cycle `ack_o` is seen, and sample data at the end of that cycle.
- Maximum throughput is one transfer per 2 cycles (IDLE + ACK) at WAIT_STATES=0.
  - This matches the fetch unit's request/wait pairs: low half in s0/s1, high half in s2/s3.
- The responder never asserts `ack_o` in two consecutive cycles.

## Structure
- Shared package `bus_pkg`:
  - Size encodings SIZE_IDLE/SIZE_BYTE/SIZE_HALF/SIZE_ILL.
  - Reset vector constant 64'hFFFF_FFFF_FFFF_FF00.
  - Responder state encoding.
- One sub-module, `hw_ram`: a 2^DEPTH_LOG2 × 16 synchronous RAM with one write port and one read port. Its read is registered, which aligns with the ACK-cycle data.
- Control FSM, decode and byte steering stay in `fetch_responder`.

## Test plan
- Reset vector, halfword reads:
  - Preload mem[0x380]=16'hAAAA and mem[0x381]=16'hBBBB.
  - Halfword read at FF00, then at FF02, with WAIT_STATES=0.
  - Expect `ack_o` one cycle after each request, `dat_o` AAAA then BBBB, `err_o` 0.
  - Expect no ack in the gap cycle between the two transfers.
- Wait states:
  - Set WAIT_STATES=3 and read FF00.
  - Expect `ack_o` exactly 4 cycles after the request, asserted for 1 cycle, `dat_o`=AAAA.
- Byte lanes:
  - Byte read at FF00: expect 16'h00AA.
  - Byte read at FF01 with mem[0x380]=16'h12AA: expect 16'h0012.
- Faults: each of the following must produce ack, `err_o`=1, `dat_o`=0000:
  - Halfword read at FF01.
  - Size 11 at FF00.
  - Halfword read at 64'h0000_0000_0000_0000.
- Abort and reset:
  - WAIT_STATES=3; drop `size_i` to 00 after 1 wait cycle: expect no ack.
  - Separately, assert `reset_ni`=0 during WAIT: expect `ack_o`, `dat_o` and `err_o` at 0 immediately, and no ack after release.
- Held request:
  - Keep `size_i`=10 at FF00 for 4 cycles at WAIT_STATES=0.
  - Expect ack in cycles 2 and 4 only; acks are never back-to-back.
